sdram_word_bridge: RTL

- Host-side initiator for the SDRAM controller's 16-bit host interface (wr_*/rd_*/busy/rd_ready).
- Converts RV32 data-memory requests (32-bit word, 4-bit byte enable) into one or two halfword controller transactions.
- The controller always writes full halfwords, so partial-halfword writes are done as read-modify-write (RMW).
- Sits between the CPU data-memory port and the controller.

---
 rtl/sdram_word_bridge_pkg.sv | 45 ++++
 rtl/sdram_word_bridge.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_word_bridge_pkg.sv
// Shared types for the RV32 word to SDRAM halfword bridge:
// FSM states, per-half operation codes and the RMW byte merge.
package sdram_word_bridge_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_ISSUE,
      S_WAIT_RD,
      S_CAPTURE,
      S_WAIT_IDLE,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      OP_SKIP,
      OP_READ,
      OP_WRITE,
      OP_RMW
   } half_op_e;

   function automatic half_op_e half_op(input logic       we,
                                        input logic [1:0] be2);
      half_op_e op;
      op = OP_READ;
      if (we) begin
         unique case (be2)
            2'b11:   op = OP_WRITE;
            2'b00:   op = OP_SKIP;
            default: op = OP_RMW;
         endcase
      end
      return op;
   endfunction

   function automatic logic [15:0] merge_half(input logic [15:0] rd16,
                                              input logic [15:0] wd16,
                                              input logic [1:0]  be2);
      logic [15:0] m;
      m[15:8] = be2[1] ? wd16[15:8] : rd16[15:8];
      m[7:0]  = be2[0] ? wd16[7:0]  : rd16[7:0];
      return m;
   endfunction

endpackage

// File: rtl/sdram_word_bridge.sv
// Splits 32-bit CPU accesses into one or two 16-bit SDRAM controller
// transactions, using read-modify-write for partial-halfword writes.
module sdram_word_bridge
   import sdram_word_bridge_pkg::*;
#(
   parameter int HADDR_WIDTH = 23,
   parameter int BADDR_WIDTH = HADDR_WIDTH + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mem_req,
   input  logic                   mem_we,
   input  logic [BADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_be,
   output logic                   mem_ready,
   output logic                   mem_done,
   output logic [31:0]            mem_rdata,
   output logic [HADDR_WIDTH-1:0] wr_addr,
   output logic [15:0]            wr_data,
   output logic                   wr_enable,
   output logic [HADDR_WIDTH-1:0] rd_addr,
   output logic                   rd_enable,
   input  logic [15:0]            rd_data,
   input  logic                   rd_ready,
   input  logic                   busy
);

   localparam int WIDX_W = BADDR_WIDTH - 2;

   state_e                 state_q, state_d;
   logic                   half_q, half_d;
   logic                   we_q, we_d;
   logic [WIDX_W-1:0]      widx_q, widx_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [3:0]             be_q, be_d;
   logic [15:0]            rd0_q, rd0_d;
   logic [15:0]            rd1_q, rd1_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic [15:0]            hdata_q, hdata_d;
   logic                   iswr_q, iswr_d;
   logic                   rmwwr_q, rmwwr_d;

   logic [1:0]  be2;
   logic [15:0] wd16;
   logic [15:0] rdh;
   half_op_e    op;
   logic        ready;
   logic        addr_lsb_unused;

   assign addr_lsb_unused = ^mem_addr[1:0];

   assign be2   = half_q ? be_q[3:2] : be_q[1:0];
   assign wd16  = half_q ? wdata_q[31:16] : wdata_q[15:0];
   assign rdh   = half_q ? rd1_q : rd0_q;
   assign op    = half_op(we_q, be2);
   assign ready = (state_q == S_IDLE) && !busy && rst_n;

   assign mem_ready = ready;
   assign mem_done  = (state_q == S_DONE);
   assign mem_rdata = rdata_q;
   assign wr_addr   = haddr_q;
   assign rd_addr   = haddr_q;
   assign wr_data   = hdata_q;
   assign wr_enable = (state_q == S_ISSUE) && iswr_q;
   assign rd_enable = (state_q == S_ISSUE) && !iswr_q;

   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      we_d    = we_q;
      widx_d  = widx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      rdata_d = rdata_q;
      haddr_d = haddr_q;
      hdata_d = hdata_q;
      iswr_d  = iswr_q;
      rmwwr_d = rmwwr_q;
      unique case (state_q)
         S_IDLE: begin
            if (mem_req && ready) begin
               we_d    = mem_we;
               widx_d  = mem_addr[BADDR_WIDTH-1:2];
               wdata_d = mem_wdata;
               be_d    = mem_be;
               half_d  = 1'b0;
               rmwwr_d = 1'b0;
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            if (!busy) begin
               unique case (op)
                  OP_SKIP: begin
                     if (half_q) state_d = S_DONE;
                     else        half_d  = 1'b1;
                  end
                  OP_WRITE: begin
                     haddr_d = {widx_q, half_q};
                     hdata_d = wd16;
                     iswr_d  = 1'b1;
                     state_d = S_ISSUE;
                  end
                  default: begin
                     haddr_d = {widx_q, half_q};
                     iswr_d  = 1'b0;
                     state_d = S_ISSUE;
                  end
               endcase
            end
         end
         // The enable is held until the controller shows busy, since
         // a refresh can silently swallow a single-cycle request.
         S_ISSUE: begin
            if (busy) state_d = iswr_q ? S_WAIT_IDLE : S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (rd_ready) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (half_q) rd1_d = rd_data;
            else        rd0_d = rd_data;
            state_d = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (!busy) begin
               if (op == OP_RMW && !rmwwr_q) begin
                  rmwwr_d = 1'b1;
                  hdata_d = merge_half(rdh, wd16, be2);
                  iswr_d  = 1'b1;
                  state_d = S_ISSUE;
               end else begin
                  rmwwr_d = 1'b0;
                  if (half_q) begin
                     state_d = S_DONE;
                     if (!we_q) rdata_d = {rd1_q, rd0_q};
                  end else begin
                     half_d  = 1'b1;
                     state_d = S_SEL;
                  end
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         half_q  <= 1'b0;
         we_q    <= 1'b0;
         widx_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
         rdata_q <= '0;
         haddr_q <= '0;
         hdata_q <= '0;
         iswr_q  <= 1'b0;
         rmwwr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         we_q    <= we_d;
         widx_q  <= widx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
         rdata_q <= rdata_d;
         haddr_q <= haddr_d;
         hdata_q <= hdata_d;
         iswr_q  <= iswr_d;
         rmwwr_q <= rmwwr_d;
      end
   end

endmodule
